// File: rtl/hazard_forward_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forward_unit_pkg
//  Description : Shared forwarding-select encoding, mult/div scoreboard state
//                encoding and producer-slot indices for the hazard unit and
//                the datapath bypass muxes.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_forward_unit_pkg;

    // Operand source selects driven to the bypass muxes
    localparam logic [1:0] FWD_RF = 2'd0;   // register file
    localparam logic [1:0] FWD_XM = 2'd1;   // X/M latch result
    localparam logic [1:0] FWD_MW = 2'd2;   // M/W latch result
    localparam logic [1:0] FWD_MD = 2'd3;   // mult/div unit result

    // Mult/div scoreboard states
    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_BUSY = 2'd1,
        SB_PEND = 2'd2
    } sb_state_t;

    // Producer slot order in the match vectors. DX is the top slot so the
    // execute-stage operands can use the lower slice only.
    localparam int P_XM  = 0;
    localparam int P_MW  = 1;
    localparam int P_MD  = 2;
    localparam int P_DX  = 3;
    localparam int NP_X  = 3;
    localparam int NP_FD = 4;

    // Nearest-stage-wins select. A load in XM has no data yet, so it falls
    // through to older producers.
    function automatic logic [1:0] fwd_pick(
        input logic xm_hit,
        input logic xm_is_load,
        input logic mw_hit,
        input logic md_hit
    );
        if (xm_hit && !xm_is_load) return FWD_XM;
        else if (mw_hit)           return FWD_MW;
        else if (md_hit)           return FWD_MD;
        else                       return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_forward_unit_src_match.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_src_match
//  Description : Compares one source register index against a list of
//                producer destinations. Register 0 never matches.
//  Ports       : i_src      source register index
//                i_prod_rd  producer destination indices (slot order per pkg)
//                i_prod_we  producer write enables
//                o_hit      per-producer match flags
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_src_match
    import hazard_forward_unit_pkg::*;
#(
    parameter int RW = 5,
    parameter int NP = NP_FD
) (
    input  logic [RW-1:0]          i_src,
    input  logic [NP-1:0][RW-1:0]  i_prod_rd,
    input  logic [NP-1:0]          i_prod_we,
    output logic [NP-1:0]          o_hit
);

    logic w_src_nz;
    assign w_src_nz = |i_src;

    genvar p;
    generate
        for (p = 0; p < NP; p++) begin : g_prod
            assign o_hit[p] = w_src_nz && i_prod_we[p] && (i_prod_rd[p] == i_src);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forward_unit
//  Description : Forwarding selects, load-use / branch hazard detection,
//                single-entry mult/div scoreboard with writeback-port
//                arbitration, and a saturating stall-cycle counter.
//  Ports       : clock/reset        pipeline clock, async active-low reset
//                fd_* / dx_* / xm_* / mw_*  decoded stage register fields
//                md_done            mult/div result-valid pulse
//                fwd_fd_*, fwd_x_*  operand selects (FWD_* encoding)
//                fwd_mem            store data from M/W
//                stall_fd, bubble_dx, stall_all   pipeline control
//                md_wb_grant, md_busy             scoreboard status
//                stall_count        saturating stall_fd cycle count
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int RW     = 5,
    parameter int PERF_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [RW-1:0]     fd_rs,
    input  logic [RW-1:0]     fd_rt,
    input  logic              fd_rs_used,
    input  logic              fd_rt_used,
    input  logic              fd_is_branch,
    input  logic [RW-1:0]     dx_rs,
    input  logic [RW-1:0]     dx_rt,
    input  logic [RW-1:0]     dx_rd,
    input  logic              dx_we,
    input  logic              dx_is_load,
    input  logic              dx_is_md,
    input  logic [RW-1:0]     xm_rd,
    input  logic              xm_we,
    input  logic              xm_is_load,
    input  logic              xm_is_store,
    input  logic [RW-1:0]     xm_rt,
    input  logic [RW-1:0]     mw_rd,
    input  logic              mw_we,
    input  logic              md_done,
    output logic [1:0]        fwd_fd_a,
    output logic [1:0]        fwd_fd_b,
    output logic [1:0]        fwd_x_a,
    output logic [1:0]        fwd_x_b,
    output logic              fwd_mem,
    output logic              stall_fd,
    output logic              bubble_dx,
    output logic              stall_all,
    output logic              md_wb_grant,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_count
);

    sb_state_t                r_state;
    sb_state_t                w_state_nxt;
    logic                     w_capture;
    logic [RW-1:0]            r_md_rd;
    logic [PERF_W-1:0]        r_stall_count;

    logic [NP_FD-1:0][RW-1:0] w_prod_rd;
    logic [NP_FD-1:0]         w_prod_we;
    logic [NP_FD-1:0]         w_hit_fd_rs;
    logic [NP_FD-1:0]         w_hit_fd_rt;
    logic [NP_X-1:0]          w_hit_dx_rs;
    logic [NP_X-1:0]          w_hit_dx_rt;

    logic w_in_busy, w_in_pend, w_grant, w_stall_all;
    logic w_fd_dx_hit, w_fd_xm_hit, w_fd_md_hit;
    logic w_load_use, w_branch_haz, w_md_haz, w_hazard, w_stall_fd;

    // ---------------------------------------------------------------- matches
    // The md slot is enabled whenever an op is outstanding; forwarding and
    // hazard paths apply their own grant/BUSY qualification on top.
    assign w_prod_rd[P_XM] = xm_rd;
    assign w_prod_rd[P_MW] = mw_rd;
    assign w_prod_rd[P_MD] = r_md_rd;
    assign w_prod_rd[P_DX] = dx_rd;
    assign w_prod_we[P_XM] = xm_we;
    assign w_prod_we[P_MW] = mw_we;
    assign w_prod_we[P_MD] = (r_state != SB_IDLE);
    assign w_prod_we[P_DX] = dx_we;

    hazard_src_match #(.RW(RW), .NP(NP_FD)) u_fd_rs (
        .i_src(fd_rs), .i_prod_rd(w_prod_rd), .i_prod_we(w_prod_we), .o_hit(w_hit_fd_rs));
    hazard_src_match #(.RW(RW), .NP(NP_FD)) u_fd_rt (
        .i_src(fd_rt), .i_prod_rd(w_prod_rd), .i_prod_we(w_prod_we), .o_hit(w_hit_fd_rt));
    hazard_src_match #(.RW(RW), .NP(NP_X)) u_dx_rs (
        .i_src(dx_rs), .i_prod_rd(w_prod_rd[NP_X-1:0]), .i_prod_we(w_prod_we[NP_X-1:0]),
        .o_hit(w_hit_dx_rs));
    hazard_src_match #(.RW(RW), .NP(NP_X)) u_dx_rt (
        .i_src(dx_rt), .i_prod_rd(w_prod_rd[NP_X-1:0]), .i_prod_we(w_prod_we[NP_X-1:0]),
        .o_hit(w_hit_dx_rt));

    // ---------------------------------------------------------------- hazards
    assign w_in_busy   = (r_state == SB_BUSY);
    assign w_in_pend   = (r_state == SB_PEND);
    // Direct grant only when M/W leaves the write port free; otherwise the
    // result is parked in PEND and the whole pipe freezes for one cycle.
    assign w_grant     = (w_in_busy && md_done && !mw_we) || w_in_pend;
    assign w_stall_all = w_in_pend;

    assign w_fd_dx_hit = (fd_rs_used && w_hit_fd_rs[P_DX]) || (fd_rt_used && w_hit_fd_rt[P_DX]);
    assign w_fd_xm_hit = (fd_rs_used && w_hit_fd_rs[P_XM]) || (fd_rt_used && w_hit_fd_rt[P_XM]);
    assign w_fd_md_hit = (fd_rs_used && w_hit_fd_rs[P_MD]) || (fd_rt_used && w_hit_fd_rt[P_MD]);

    assign w_load_use   = dx_is_load && w_fd_dx_hit;
    assign w_branch_haz = fd_is_branch && (w_fd_dx_hit || (xm_is_load && w_fd_xm_hit));
    assign w_md_haz     = w_in_busy && (w_fd_md_hit || dx_is_md);
    assign w_hazard     = w_load_use || w_branch_haz || w_md_haz;
    assign w_stall_fd   = w_stall_all || w_hazard;

    // ---------------------------------------------------------------- outputs
    assign fwd_x_a  = reset ? fwd_pick(w_hit_dx_rs[P_XM], xm_is_load, w_hit_dx_rs[P_MW],
                                       w_hit_dx_rs[P_MD] && w_grant) : FWD_RF;
    assign fwd_x_b  = reset ? fwd_pick(w_hit_dx_rt[P_XM], xm_is_load, w_hit_dx_rt[P_MW],
                                       w_hit_dx_rt[P_MD] && w_grant) : FWD_RF;
    assign fwd_fd_a = (reset && fd_is_branch) ?
                      fwd_pick(w_hit_fd_rs[P_XM], xm_is_load, w_hit_fd_rs[P_MW],
                               w_hit_fd_rs[P_MD] && w_grant) : FWD_RF;
    assign fwd_fd_b = (reset && fd_is_branch) ?
                      fwd_pick(w_hit_fd_rt[P_XM], xm_is_load, w_hit_fd_rt[P_MW],
                               w_hit_fd_rt[P_MD] && w_grant) : FWD_RF;
    assign fwd_mem     = reset && xm_is_store && mw_we && (xm_rt == mw_rd) && (|mw_rd);
    assign stall_fd    = reset && w_stall_fd;
    assign bubble_dx   = reset && w_hazard && !w_stall_all;
    assign stall_all   = reset && w_stall_all;
    assign md_wb_grant = reset && w_grant;
    assign md_busy     = reset && (r_state != SB_IDLE);
    assign stall_count = r_stall_count;

    // ------------------------------------------------------------- scoreboard
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            SB_IDLE: begin
                // md_done here is a stale pulse and is ignored
                if (dx_is_md && dx_we && (|dx_rd) && !w_stall_all) begin
                    w_state_nxt = SB_BUSY;
                    w_capture   = 1'b1;
                end
            end
            SB_BUSY: begin
                if (md_done) w_state_nxt = mw_we ? SB_PEND : SB_IDLE;
            end
            SB_PEND: w_state_nxt = SB_IDLE;
            default: w_state_nxt = SB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= SB_IDLE;
            r_md_rd <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) r_md_rd <= dx_rd;
        end
    end

    // Frozen cycles are not counted; counter sticks at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_count <= '0;
        end else if (w_stall_fd && !w_stall_all && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + PERF_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_forward_unit
//  Description : Directed bench for hazard_forward_unit with a cycle-level
//                reference model compared on every falling clock edge and
//                hand-computed spot checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_forward_unit;

    localparam int RW   = 5;
    localparam int PW   = 8;
    localparam int MAXC = (1 << PW) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [RW-1:0] fd_rs, fd_rt, dx_rs, dx_rt, dx_rd, xm_rd, xm_rt, mw_rd;
    logic fd_rs_used, fd_rt_used, fd_is_branch, dx_we, dx_is_load, dx_is_md;
    logic xm_we, xm_is_load, xm_is_store, mw_we, md_done;
    logic [1:0] fwd_fd_a, fwd_fd_b, fwd_x_a, fwd_x_b;
    logic fwd_mem, stall_fd, bubble_dx, stall_all, md_wb_grant, md_busy;
    logic [PW-1:0] stall_count;

    int n_vec   = 0;
    int n_err   = 0;
    int n_print = 0;

    // reference model state: phase 0 = nothing outstanding, 1 = executing,
    // 2 = result parked waiting for the write port
    int m_phase = 0;
    int m_md_rd = 0;
    int m_cnt   = 0;

    typedef struct packed {
        logic [1:0] fd_a, fd_b, x_a, x_b;
        logic mem, sfd, bub, sall, grant, busy;
        logic [PW-1:0] cnt;
    } exp_t;

    hazard_forward_unit #(.RW(RW), .PERF_W(PW)) dut (
        .clock(clock), .reset(reset),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rs_used(fd_rs_used), .fd_rt_used(fd_rt_used),
        .fd_is_branch(fd_is_branch),
        .dx_rs(dx_rs), .dx_rt(dx_rt), .dx_rd(dx_rd), .dx_we(dx_we),
        .dx_is_load(dx_is_load), .dx_is_md(dx_is_md),
        .xm_rd(xm_rd), .xm_we(xm_we), .xm_is_load(xm_is_load), .xm_is_store(xm_is_store),
        .xm_rt(xm_rt), .mw_rd(mw_rd), .mw_we(mw_we), .md_done(md_done),
        .fwd_fd_a(fwd_fd_a), .fwd_fd_b(fwd_fd_b), .fwd_x_a(fwd_x_a), .fwd_x_b(fwd_x_b),
        .fwd_mem(fwd_mem), .stall_fd(stall_fd), .bubble_dx(bubble_dx), .stall_all(stall_all),
        .md_wb_grant(md_wb_grant), .md_busy(md_busy), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------ model
    function automatic bit hit(input int src, input int rd, input bit we);
        return we && (src != 0) && (src == rd);
    endfunction

    function automatic bit used_hit(input int rd, input bit we);
        return (fd_rs_used && hit(int'(fd_rs), rd, we)) || (fd_rt_used && hit(int'(fd_rt), rd, we));
    endfunction

    function automatic logic [1:0] sel(input int src, input bit grant);
        if (hit(src, int'(xm_rd), xm_we) && !xm_is_load) return 2'd1;
        if (hit(src, int'(mw_rd), mw_we))                return 2'd2;
        if (grant && hit(src, m_md_rd, 1'b1))            return 2'd3;
        return 2'd0;
    endfunction

    function automatic exp_t model();
        exp_t e;
        bit grant, frozen, hz;
        e = '0;
        if (reset !== 1'b1) return e;
        frozen = (m_phase == 2);
        grant  = (m_phase == 1 && md_done && !mw_we) || frozen;
        e.x_a = sel(int'(dx_rs), grant);
        e.x_b = sel(int'(dx_rt), grant);
        if (fd_is_branch) begin
            e.fd_a = sel(int'(fd_rs), grant);
            e.fd_b = sel(int'(fd_rt), grant);
        end
        e.mem = xm_is_store && mw_we && (xm_rt == mw_rd) && (mw_rd != 0);
        hz = 1'b0;
        if (dx_is_load && used_hit(int'(dx_rd), dx_we)) hz = 1'b1;
        if (fd_is_branch && (used_hit(int'(dx_rd), dx_we) ||
                             (xm_is_load && used_hit(int'(xm_rd), xm_we)))) hz = 1'b1;
        if (m_phase == 1 && (used_hit(m_md_rd, 1'b1) || dx_is_md)) hz = 1'b1;
        e.sfd   = hz || frozen;
        e.bub   = hz && !frozen;
        e.sall  = frozen;
        e.grant = grant;
        e.busy  = (m_phase != 0);
        e.cnt   = PW'(m_cnt);
        return e;
    endfunction

    initial forever begin
        exp_t e;
        @(posedge clock or negedge reset);
        if (reset !== 1'b1) begin
            m_phase = 0; m_md_rd = 0; m_cnt = 0;
        end else begin
            e = model();
            if (e.sfd && !e.sall && m_cnt < MAXC) m_cnt = m_cnt + 1;
            case (m_phase)
                0: if (dx_is_md && dx_we && dx_rd != 0) begin
                       m_phase = 1; m_md_rd = int'(dx_rd);
                   end
                1: if (md_done) m_phase = mw_we ? 2 : 0;
                default: m_phase = 0;
            endcase
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            if (n_print < 50) begin
                n_print++;
                $display("FAIL model %s @%0t: got %0d, expected %0d", name, $time, act, exp);
            end
        end
    endtask

    initial forever begin
        exp_t e;
        @(negedge clock);
        e = model();
        n_vec++;
        cmp("fwd_fd_a", 32'(fwd_fd_a), 32'(e.fd_a));
        cmp("fwd_fd_b", 32'(fwd_fd_b), 32'(e.fd_b));
        cmp("fwd_x_a", 32'(fwd_x_a), 32'(e.x_a));
        cmp("fwd_x_b", 32'(fwd_x_b), 32'(e.x_b));
        cmp("fwd_mem", 32'(fwd_mem), 32'(e.mem));
        cmp("stall_fd", 32'(stall_fd), 32'(e.sfd));
        cmp("bubble_dx", 32'(bubble_dx), 32'(e.bub));
        cmp("stall_all", 32'(stall_all), 32'(e.sall));
        cmp("md_wb_grant", 32'(md_wb_grant), 32'(e.grant));
        cmp("md_busy", 32'(md_busy), 32'(e.busy));
        cmp("stall_count", 32'(stall_count), 32'(e.cnt));
    end

    // ------------------------------------------------------------- directed
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        fd_rs = '0; fd_rt = '0; dx_rs = '0; dx_rt = '0; dx_rd = '0;
        xm_rd = '0; xm_rt = '0; mw_rd = '0;
        fd_rs_used = 0; fd_rt_used = 0; fd_is_branch = 0;
        dx_we = 0; dx_is_load = 0; dx_is_md = 0;
        xm_we = 0; xm_is_load = 0; xm_is_store = 0; mw_we = 0; md_done = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear_inputs();
        // reset gates combinational outputs even with hazards present
        xm_we = 1; xm_rd = 5; dx_rs = 5; fd_is_branch = 1; fd_rs = 5; fd_rs_used = 1;
        dx_we = 1; dx_rd = 5; dx_is_load = 1;
        #2;
        chk("rst_fwd_x_a", 32'(fwd_x_a), 0);
        chk("rst_stall_fd", 32'(stall_fd), 0);
        chk("rst_bubble", 32'(bubble_dx), 0);
        chk("rst_cnt", 32'(stall_count), 0);
        tick(); clear_inputs(); reset = 1;

        // execute-stage forwarding priority
        tick(); xm_we = 1; xm_rd = 5; mw_we = 1; mw_rd = 5; dx_rs = 5;
        #1 chk("x_a_xm", 32'(fwd_x_a), 1);
        tick(); xm_rd = 6;
        #1 chk("x_a_mw", 32'(fwd_x_a), 2);
        tick(); xm_rd = 0; mw_rd = 0;
        #1 chk("x_a_r0", 32'(fwd_x_a), 0);
        tick(); xm_rd = 5; xm_is_load = 1; mw_rd = 5; dx_rt = 5;
        #1 chk("x_b_xm_load", 32'(fwd_x_b), 2);
        tick(); clear_inputs(); xm_is_store = 1; xm_rt = 4; mw_we = 1; mw_rd = 4;
        #1 chk("fwd_mem", 32'(fwd_mem), 1);
        tick(); xm_rt = 0; mw_rd = 0;
        #1 chk("fwd_mem_r0", 32'(fwd_mem), 0);

        // load-use
        tick(); clear_inputs(); dx_is_load = 1; dx_we = 1; dx_rd = 7; fd_rs = 7; fd_rs_used = 1;
        #1 chk("lu_stall", 32'(stall_fd), 1);
        chk("lu_bubble", 32'(bubble_dx), 1);
        tick(); clear_inputs(); xm_rd = 7; xm_we = 1; xm_is_load = 1; dx_rs = 7;
        fd_rs = 8; fd_rs_used = 1;
        #1 chk("lu_xm_nostall", 32'(stall_fd), 0);
        chk("lu_xm_fwd", 32'(fwd_x_a), 0);
        tick(); clear_inputs(); mw_rd = 7; mw_we = 1; dx_rs = 7;
        #1 chk("lu_mw_fwd", 32'(fwd_x_a), 2);
        chk("lu_cnt", 32'(stall_count), 1);

        // branch hazards
        tick(); clear_inputs(); fd_is_branch = 1; fd_rs = 3; fd_rs_used = 1; dx_rd = 3; dx_we = 1;
        #1 chk("br_dx_stall", 32'(stall_fd), 1);
        chk("br_dx_bubble", 32'(bubble_dx), 1);
        tick(); dx_we = 0; dx_rd = 0; xm_rd = 3; xm_we = 1;
        #1 chk("br_xm_nostall", 32'(stall_fd), 0);
        chk("br_xm_fwd", 32'(fwd_fd_a), 1);
        tick(); xm_is_load = 1;
        #1 chk("br_xmload_stall", 32'(stall_fd), 1);
        tick(); clear_inputs();
        #1 chk("br_cnt", 32'(stall_count), 3);

        // mult/div, direct grant
        tick(); reset = 0;
        #1 chk("rst2_cnt", 32'(stall_count), 0);
        tick(); reset = 1; dx_is_md = 1; dx_we = 1; dx_rd = 9;
        #1 chk("md_issue_idle", 32'(md_busy), 0);
        tick(); clear_inputs(); fd_rs = 9; fd_rs_used = 1;
        #1 chk("md_busy", 32'(md_busy), 1);
        chk("md_raw_stall", 32'(stall_fd), 1);
        repeat (10) tick();
        fd_rs_used = 0; md_done = 1; dx_rs = 9;
        #1 chk("md_cnt10", 32'(stall_count), 10);
        chk("md_grant", 32'(md_wb_grant), 1);
        chk("md_fwd_x", 32'(fwd_x_a), 3);
        tick(); md_done = 0;
        #1 chk("md_idle", 32'(md_busy), 0);
        chk("md_grant_off", 32'(md_wb_grant), 0);

        // mult/div, port conflict -> PEND
        tick(); clear_inputs(); dx_is_md = 1; dx_we = 1; dx_rd = 12;
        tick(); dx_rd = 13;
        #1 chk("md_second_stall", 32'(stall_fd), 1);
        tick(); clear_inputs(); md_done = 1; mw_we = 1; mw_rd = 4;
        #1 chk("pend_no_grant", 32'(md_wb_grant), 0);
        tick(); clear_inputs(); dx_is_load = 1; dx_we = 1; dx_rd = 7; fd_rs = 7; fd_rs_used = 1;
        dx_rs = 12;
        #1 chk("pend_grant", 32'(md_wb_grant), 1);
        chk("pend_stall_all", 32'(stall_all), 1);
        chk("pend_stall_fd", 32'(stall_fd), 1);
        chk("pend_bubble", 32'(bubble_dx), 0);
        chk("pend_fwd", 32'(fwd_x_a), 3);
        chk("pend_cnt", 32'(stall_count), 11);
        tick(); clear_inputs();
        #1 chk("pend_cnt_hold", 32'(stall_count), 11);
        chk("pend_done", 32'(md_busy), 0);

        // async reset mid-BUSY drops the op
        tick(); dx_is_md = 1; dx_we = 1; dx_rd = 9;
        tick(); clear_inputs(); dx_rs = 9; xm_rd = 9; xm_we = 1;
        #1 chk("arst_pre_fwd", 32'(fwd_x_a), 1);
        reset = 0;
        #1 chk("arst_busy", 32'(md_busy), 0);
        chk("arst_fwd", 32'(fwd_x_a), 0);
        chk("arst_cnt", 32'(stall_count), 0);
        tick(); reset = 1; clear_inputs(); md_done = 1; dx_rs = 9;
        #1 chk("arst_no_grant", 32'(md_wb_grant), 0);
        chk("arst_no_fwd", 32'(fwd_x_a), 0);

        // counter saturation
        tick(); clear_inputs(); dx_is_load = 1; dx_we = 1; dx_rd = 7; fd_rs = 7; fd_rs_used = 1;
        repeat ((1 << PW) + 3) tick();
        #1 chk("sat_cnt", 32'(stall_count), MAXC);
        chk("sat_stall", 32'(stall_fd), 1);
        tick(); clear_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
